// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset PC default and fetch FSM state encodings.
package fetch_unit_pkg;

    localparam int              FETCH_WORD_W   = 16;
    localparam logic [15:0]     FETCH_RESET_PC = 16'h0000;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load of a jump target wins over increment.
module fetch_pc
    import fetch_unit_pkg::*;
#(
    parameter int                WORD_W   = FETCH_WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] target_i,
    output logic [WORD_W-1:0] pc_o
);

    logic [WORD_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = target_i;
        else if (inc_i)
            pc_d = pc_q + WORD_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads program memory, strobes the IR, holds until decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                WORD_W      = FETCH_WORD_W,
    parameter logic [WORD_W-1:0] RESET_PC    = WORD_W'(FETCH_RESET_PC),
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] ir_data,
    output logic              ir_notLoad,
    output logic              ir_valid,
    input  logic              decode_ready,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] pc,
    output logic              fetch_error
);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic              err_q, err_d;
    logic              rd_q;
    logic              pc_inc, pc_load;

    // rd_q is low for the first cycle after reset, so a FETCH only acts
    // once its read request has actually been presented to memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        err_d   = err_q;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (rd_q) begin
                    if (mem_ready) begin
                        ir_d    = mem_data;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == 8'(MEM_TIMEOUT)) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_LOAD: begin
                pc_inc  = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (decode_ready) begin
                    pc_load = jump;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            rd_q    <= (state_d == ST_FETCH);
        end
    end

    fetch_pc #(
        .WORD_W   (WORD_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock    (clock),
        .reset    (reset),
        .inc_i    (pc_inc),
        .load_i   (pc_load),
        .target_i (jump_target),
        .pc_o     (pc)
    );

    assign mem_addr    = pc;
    assign mem_read    = rd_q;
    assign ir_data     = ir_q;
    assign ir_notLoad  = (state_q != ST_LOAD);
    assign ir_valid    = (state_q == ST_ISSUE);
    assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance covers PC wrap from 16'hFFFF.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = '0;
    logic        decode_ready = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jump_target = '0;

    logic [15:0] mem_addr, ir_data, pc;
    logic        mem_read, ir_notLoad, ir_valid, fetch_error;
    logic [15:0] mem_addr2, ir_data2, pc2;
    logic        mem_read2, ir_notLoad2, ir_valid2, fetch_error2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fetch_unit #(.WORD_W(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready), .mem_data(mem_data),
        .ir_data(ir_data), .ir_notLoad(ir_notLoad), .ir_valid(ir_valid),
        .decode_ready(decode_ready), .jump(jump), .jump_target(jump_target),
        .pc(pc), .fetch_error(fetch_error)
    );

    fetch_unit #(.WORD_W(16), .RESET_PC(16'hFFFF), .MEM_TIMEOUT(15)) dut2 (
        .clock(clock), .reset(reset),
        .mem_addr(mem_addr2), .mem_read(mem_read2), .mem_ready(mem_ready), .mem_data(mem_data),
        .ir_data(ir_data2), .ir_notLoad(ir_notLoad2), .ir_valid(ir_valid2),
        .decode_ready(decode_ready), .jump(jump), .jump_target(jump_target),
        .pc(pc2), .fetch_error(fetch_error2)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        mem_ready    = 1'b0;
        decode_ready = 1'b0;
        jump         = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},  pc, 16'h0000);
        chk({tag, "_ir"},  ir_data, 16'h0000);
        chk({tag, "_nld"}, 16'(ir_notLoad), 16'd1);
        chk({tag, "_vld"}, 16'(ir_valid), 16'd0);
        chk({tag, "_rd"},  16'(mem_read), 16'd0);
        chk({tag, "_err"}, 16'(fetch_error), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic fetch with immediate mem_ready
        tick();
        do_reset();
        chk_reset_state("rst");
        tick();
        chk("f1_rd",   16'(mem_read), 16'd1);
        chk("f1_addr", mem_addr, 16'h0000);
        mem_ready = 1'b1; mem_data = 16'b1010111_101_110_011; decode_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("f1_nld",   16'(ir_notLoad), 16'd0);
        chk("f1_ir",    ir_data, 16'hAF73);
        chk("f1_ldrd",  16'(mem_read), 16'd0);
        tick();
        chk("f1_nld2",  16'(ir_notLoad), 16'd1);
        chk("f1_vld",   16'(ir_valid), 16'd1);
        chk("f1_pc",    pc, 16'h0001);
        chk("f1_isrd",  16'(mem_read), 16'd0);
        tick();
        chk("f1_rd2",   16'(mem_read), 16'd1);
        chk("f1_addr2", mem_addr, 16'h0001);

        // mem_ready delayed 4 cycles
        for (int i = 0; i < 5; i++) begin
            chk("dly_rd",   16'(mem_read), 16'd1);
            chk("dly_addr", mem_addr, 16'h0001);
            chk("dly_nld",  16'(ir_notLoad), 16'd1);
            if (i == 4) begin mem_ready = 1'b1; mem_data = 16'h1234; end
            tick();
        end
        mem_ready = 1'b0; decode_ready = 1'b0;
        chk("dly_nld0", 16'(ir_notLoad), 16'd0);
        chk("dly_ir",   ir_data, 16'h1234);
        chk("dly_err",  16'(fetch_error), 16'd0);
        tick();

        // decode stall; jump must be ignored while decode_ready is low
        jump = 1'b1; jump_target = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            chk("stl_vld", 16'(ir_valid), 16'd1);
            chk("stl_ir",  ir_data, 16'h1234);
            chk("stl_pc",  pc, 16'h0002);
            chk("stl_rd",  16'(mem_read), 16'd0);
            chk("stl_nld", 16'(ir_notLoad), 16'd1);
            tick();
        end
        jump = 1'b0; decode_ready = 1'b1;
        tick();
        chk("rel_rd",   16'(mem_read), 16'd1);
        chk("rel_addr", mem_addr, 16'h0002);

        // taken jump
        mem_ready = 1'b1; mem_data = 16'h5555;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("jmp_pc3", pc, 16'h0003);
        jump = 1'b1; jump_target = 16'h0040; decode_ready = 1'b1;
        tick();
        jump = 1'b0;
        chk("jmp_addr", mem_addr, 16'h0040);
        chk("jmp_rd",   16'(mem_read), 16'd1);

        // jump without decode_ready has no effect
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; decode_ready = 1'b0; jump = 1'b1; jump_target = 16'h0077;
        tick();
        tick();
        chk("njmp_pc",  pc, 16'h0041);
        chk("njmp_vld", 16'(ir_valid), 16'd1);
        jump = 1'b0; decode_ready = 1'b1;
        tick();
        chk("njmp_addr", mem_addr, 16'h0041);

        // memory timeout
        for (int i = 0; i < 15; i++) begin
            chk("to_rd",  16'(mem_read), 16'd1);
            chk("to_err", 16'(fetch_error), 16'd0);
            tick();
        end
        chk("to_err1", 16'(fetch_error), 16'd1);
        chk("to_rd0",  16'(mem_read), 16'd0);
        chk("to_vld",  16'(ir_valid), 16'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_err", 16'(fetch_error), 16'd1);
            chk("halt_rd",  16'(mem_read), 16'd0);
            chk("halt_nld", 16'(ir_notLoad), 16'd1);
        end
        do_reset();
        chk_reset_state("rst2");

        // reset during FETCH with mem_ready in the reset cycle
        tick();
        chk("rf_rd", 16'(mem_read), 16'd1);
        reset = 1'b1; mem_ready = 1'b1; mem_data = 16'hBEEF;
        tick();
        chk("rf_nld", 16'(ir_notLoad), 16'd1);
        chk("rf_rd0", 16'(mem_read), 16'd0);
        chk("rf_ir",  ir_data, 16'h0000);
        reset = 1'b0; mem_ready = 1'b0;
        tick();
        chk("rf_nld2", 16'(ir_notLoad), 16'd1);
        chk("rf_rd1",  16'(mem_read), 16'd1);

        // PC wrap on the RESET_PC=FFFF instance
        do_reset();
        chk("wr_pc", pc2, 16'hFFFF);
        tick();
        chk("wr_addr0", mem_addr2, 16'hFFFF);
        chk("wr_rd0",   16'(mem_read2), 16'd1);
        mem_ready = 1'b1; mem_data = 16'h0F0F; decode_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wr_nld", 16'(ir_notLoad2), 16'd0);
        tick();
        chk("wr_pc1", pc2, 16'h0000);
        tick();
        chk("wr_addr1", mem_addr2, 16'h0000);
        chk("wr_rd1",   16'(mem_read2), 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
